// File: rtl/eth_bf_spi_pkg.sv
// eth_bf_spi_pkg: shared types and constants for the Blackfin SPI slave register bank
package eth_bf_spi_pkg;
   typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_e;
   localparam int CMD_W = 8;
   localparam int RD_BIT = 7;
   localparam logic [6:0] STATUS_ADDR = 7'h7F;
endpackage

// File: rtl/spi_in_sync.sv
// spi_in_sync: per-bit multi-stage synchroniser with rise/fall strobes on the synchronised copy
module spi_in_sync #(
   parameter int W = 1,
   parameter int STAGES = 2,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o,
   output logic [W-1:0] rise_o,
   output logic [W-1:0] fall_o
);
   logic [W-1:0] sync_q [STAGES];
   logic [W-1:0] prev_q;
   // shift pins through the chain and keep the last synchronised value for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) sync_q[i] <= RST_VAL;
         prev_q <= RST_VAL;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= sync_q[STAGES-1];
      end
   end
   assign q_o = sync_q[STAGES-1];
   assign rise_o = q_o & ~prev_q;
   assign fall_o = ~q_o & prev_q;
endmodule

// File: rtl/eth_bf_spi_slave.sv
// eth_bf_spi_slave: oversampled SPI mode-0 slave exposing a register bank, status word and sticky irq
module eth_bf_spi_slave
   import eth_bf_spi_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 7,
   parameter int NREG = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   SCK,
   input  logic                   CS_N,
   input  logic                   MOSI,
   output logic                   MISO,
   output logic                   MISO_OE,
   output logic [NREG*DATA_W-1:0] regs_out,
   input  logic [DATA_W-1:0]      status_in,
   input  logic                   irq_in,
   output logic                   INT_BF,
   output logic                   frame_done,
   output logic                   frame_err
);
   localparam int CNT_W = $clog2(DATA_W);
   logic [3:0] s_q, s_rise, s_fall;
   logic sck_rise, sck_fall, cs_n_s, cs_rise, cs_fall, mosi_s, irq_rise, unused_sync;
   state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CMD_W-1:0] cmd_q, cmd_d;
   logic [DATA_W-1:0] rx_q, rx_d, tx_q, tx_d, rd_word;
   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [SYNC_STAGES-1:0] fill_q;
   logic [ADDR_W-1:0] nxt_addr;
   logic miso_q, miso_d, done_q, done_d, err_q, err_d, int_q, int_d, arm_q, arm_d, clr;

   // chip select idles high through reset so MISO_OE stays off and no false frame start appears
   spi_in_sync #(.W(4), .STAGES(SYNC_STAGES), .RST_VAL(4'b0010)) u_sync (
      .clk   (clk),
      .rst   (rst),
      .d_i   ({irq_in, MOSI, CS_N, SCK}),
      .q_o   (s_q),
      .rise_o(s_rise),
      .fall_o(s_fall)
   );
   assign sck_rise = s_rise[0];
   assign sck_fall = s_fall[0];
   assign cs_n_s = s_q[1];
   assign cs_rise = s_rise[1];
   assign cs_fall = s_fall[1];
   assign mosi_s = s_q[2];
   assign irq_rise = s_rise[3];
   assign unused_sync = ^{s_rise[2], s_fall[2], s_fall[3], s_q[3]};
   assign nxt_addr = {cmd_q[ADDR_W-2:0], mosi_s};
   assign arm_d = arm_q | (fill_q[SYNC_STAGES-1] & cs_n_s);
   assign int_d = irq_rise | (int_q & ~clr);

   // read shadow source for the address completed by the current (8th) command bit
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NREG; i++) if (nxt_addr == ADDR_W'(i)) rd_word = regs_q[i];
      if (nxt_addr == STATUS_ADDR) rd_word = status_in;
   end

   // frame FSM: command/data shifting, MISO drive, register write and status-read irq clear
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      cmd_d = cmd_q;
      rx_d = rx_q;
      tx_d = tx_q;
      miso_d = miso_q;
      regs_d = regs_q;
      done_d = 1'b0;
      err_d = 1'b0;
      clr = 1'b0;
      case (state_q)
         IDLE: begin
            miso_d = 1'b0;
            if (cs_fall && arm_q) begin
               state_d = CMD;
               cnt_d = '0;
               cmd_d = '0;
            end
         end
         CMD: begin
            if (cs_rise) begin
               state_d = IDLE;
               err_d = 1'b1;
            end else if (sck_rise) begin
               cmd_d = {cmd_q[CMD_W-2:0], mosi_s};
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(CMD_W-1)) begin
                  state_d = DATA;
                  cnt_d = '0;
                  rx_d = '0;
                  tx_d = cmd_q[RD_BIT-1] ? rd_word : '0;
                  miso_d = tx_d[DATA_W-1];
               end
            end
         end
         DATA: begin
            if (cs_rise) begin
               state_d = IDLE;
               err_d = 1'b1;
               miso_d = 1'b0;
            end else if (sck_rise) begin
               rx_d = {rx_q[DATA_W-2:0], mosi_s};
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(DATA_W-1)) begin
                  state_d = DONE;
                  cnt_d = '0;
                  done_d = 1'b1;
                  miso_d = 1'b0;
                  for (int i = 0; i < NREG; i++)
                     if (!cmd_q[RD_BIT] && cmd_q[ADDR_W-1:0] == ADDR_W'(i)) regs_d[i] = rx_d;
                  clr = cmd_q[RD_BIT] && cmd_q[ADDR_W-1:0] == STATUS_ADDR;
               end
            end else if (sck_fall && cnt_q != '0) begin
               tx_d = tx_q << 1;
               miso_d = tx_q[DATA_W-2];
            end
         end
         DONE: begin
            miso_d = 1'b0;
            if (cs_rise) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // state registers; arm waits for a genuinely sampled high CS_N after reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         cmd_q <= '0;
         rx_q <= '0;
         tx_q <= '0;
         miso_q <= 1'b0;
         done_q <= 1'b0;
         err_q <= 1'b0;
         int_q <= 1'b0;
         arm_q <= 1'b0;
         fill_q <= '0;
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         cmd_q <= cmd_d;
         rx_q <= rx_d;
         tx_q <= tx_d;
         miso_q <= miso_d;
         done_q <= done_d;
         err_q <= err_d;
         int_q <= int_d;
         arm_q <= arm_d;
         fill_q <= (fill_q << 1) | SYNC_STAGES'(1);
         regs_q <= regs_d;
      end
   end

   for (genvar g = 0; g < NREG; g++) begin : g_out
      assign regs_out[g*DATA_W +: DATA_W] = regs_q[g];
   end
   assign MISO = miso_q;
   assign MISO_OE = ~cs_n_s;
   assign INT_BF = int_q;
   assign frame_done = done_q;
   assign frame_err = err_q;
endmodule

// File: tb/tb_eth_bf_spi_slave.sv
// tb_eth_bf_spi_slave: scoreboard bench driving SPI frames at clk/8 and checking each frame outcome
module tb_eth_bf_spi_slave;
   logic clk = 1'b0, rst = 1'b1, SCK = 1'b0, CS_N = 1'b1, MOSI = 1'b0, irq_in = 1'b0;
   logic MISO, MISO_OE, INT_BF, frame_done, frame_err;
   logic [127:0] regs_out;
   logic [15:0] status_in = 16'h0;
   logic [15:0] rx_w = 16'h0;
   logic [15:0] mreg [8];
   int nchk = 0, nerr = 0;

   typedef struct {
      bit err;
      logic [127:0] regs;
      logic [15:0] rd;
      bit int_bf;
   } exp_t;
   exp_t q[$];

   eth_bf_spi_slave dut (
      .clk(clk), .rst(rst), .SCK(SCK), .CS_N(CS_N), .MOSI(MOSI), .MISO(MISO), .MISO_OE(MISO_OE),
      .regs_out(regs_out), .status_in(status_in), .irq_in(irq_in), .INT_BF(INT_BF),
      .frame_done(frame_done), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] model_regs();
      logic [127:0] r;
      for (int i = 0; i < 8; i++) r[i*16 +: 16] = mreg[i];
      return r;
   endfunction

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input bit err, input logic [15:0] rd, input bit ib);
      exp_t e;
      e.err = err;
      e.regs = model_regs();
      e.rd = rd;
      e.int_bf = ib;
      q.push_back(e);
   endtask

   task automatic bits(input logic [7:0] cmd, input logic [15:0] dat, input int from, input int to);
      for (int i = from; i < to; i++) begin
         if (i < 8) MOSI = cmd[7-i];
         else MOSI = dat[23-i];
         clks(4);
         SCK = 1'b1;
         if (i >= 8) rx_w = {rx_w[14:0], MISO};
         clks(4);
         SCK = 1'b0;
      end
   endtask

   task automatic frame(input logic [7:0] cmd, input logic [15:0] dat);
      CS_N = 1'b0;
      rx_w = 16'h0;
      clks(4);
      bits(cmd, dat, 0, 24);
      clks(4);
      CS_N = 1'b1;
      clks(8);
   endtask

   // monitor: every frame_done/frame_err pulse is matched against the oldest expected outcome
   always @(negedge clk) begin
      if (frame_done || frame_err) begin
         if (q.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL unexpected_event: done=%0b err=%0b with nothing expected", frame_done, frame_err);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("frame_err", frame_err, e.err);
            check("frame_done", frame_done, !e.err);
            check("regs_out", regs_out, e.regs);
            check("int_bf", INT_BF, e.int_bf);
            if (!e.err) check("miso_word", rx_w, e.rd);
         end
      end
   end

   initial begin
      for (int i = 0; i < 8; i++) mreg[i] = 16'h0;
      clks(5);
      rst = 1'b0;
      clks(10);
      check("rst_regs", regs_out, 128'h0);
      check("rst_miso", MISO, 1'b0);
      check("rst_miso_oe", MISO_OE, 1'b0);
      check("rst_int", INT_BF, 1'b0);
      check("rst_done", frame_done, 1'b0);
      check("rst_err", frame_err, 1'b0);
      mreg[3] = 16'hBEEF;
      push(0, 16'h0, 0);
      frame(8'h03, 16'hBEEF);
      push(0, 16'hBEEF, 0);
      frame(8'h83, 16'h0);
      status_in = 16'h00A5;
      irq_in = 1'b1;
      clks(10);
      check("int_set", INT_BF, 1'b1);
      push(0, 16'h00A5, 0);
      frame(8'hFF, 16'h0);
      check("int_cleared", INT_BF, 1'b0);
      push(1, 16'h0, 0);
      CS_N = 1'b0;
      clks(4);
      check("miso_oe_active", MISO_OE, 1'b1);
      bits(8'h02, 16'h1111, 0, 18);
      clks(4);
      CS_N = 1'b1;
      clks(8);
      check("miso_oe_idle", MISO_OE, 1'b0);
      push(0, 16'h0, 0);
      frame(8'h7E, 16'h1234);
      mreg[5] = 16'hC3A6;
      push(0, 16'h0, 0);
      frame(8'h05, 16'hC3A6);
      push(0, 16'hC3A6, 0);
      frame(8'h85, 16'h0);
      mreg[7] = 16'h8001;
      push(0, 16'h0, 0);
      frame(8'h07, 16'h8001);
      push(0, 16'h8001, 0);
      frame(8'h87, 16'h0);
      push(0, 16'h0, 0);
      frame(8'h8A, 16'h0);
      irq_in = 1'b0;
      clks(10);
      CS_N = 1'b0;
      rx_w = 16'h0;
      clks(4);
      bits(8'h01, 16'hFFFF, 0, 12);
      rst = 1'b1;
      clks(3);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) mreg[i] = 16'h0;
      bits(8'h01, 16'hFFFF, 12, 24);
      clks(4);
      CS_N = 1'b1;
      clks(8);
      check("rst_mid_regs", regs_out, 128'h0);
      check("rst_mid_int", INT_BF, 1'b0);
      mreg[4] = 16'h5A5A;
      push(0, 16'h0, 0);
      frame(8'h04, 16'h5A5A);
      push(0, 16'h5A5A, 0);
      frame(8'h84, 16'h0);
      clks(20);
      check("pending_expected", 128'(q.size()), 128'h0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
